// File: rtl/in_pass_pipe_pkg.sv
// rtl/in_pass_pipe_pkg.sv - shared mode encodings and sizing helper for the input pass pipe
package in_pass_pipe_pkg;

  localparam logic [1:0] MODE_COMB  = 2'b00;
  localparam logic [1:0] MODE_REG   = 2'b01;
  localparam logic [1:0] MODE_DELAY = 2'b10;
  localparam logic [1:0] MODE_SYNC  = 2'b11;

  // Fill counter must hold the value DEPTH itself, hence depth + 1 codes.
  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/in_pass_pipe_lane.sv
// rtl/in_pass_pipe_lane.sv - one lane: CE-gated delay line, free-running synchroniser, output mux
module in_pass_pipe_lane
  import in_pass_pipe_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       i,
  input  logic [1:0] mode,
  input  logic       fill_full,
  input  logic       fill_nonzero,
  input  logic       sync_done,
  output logic       o,
  output logic       primed
);

  logic [DEPTH-1:0] stage;
  logic [1:0]       sync;

  // The delay line shifts in every mode so REG and DELAY share stage[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else if (ce) begin
      stage <= {stage[DEPTH-2:0], i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], i};
    end
  end

  always_comb begin
    o      = i;
    primed = 1'b1;
    case (mode)
      MODE_REG: begin
        o      = stage[0];
        primed = fill_nonzero;
      end
      MODE_DELAY: begin
        o      = stage[DEPTH-1];
        primed = fill_full;
      end
      MODE_SYNC: begin
        o      = sync[1];
        primed = sync_done;
      end
      default: begin
        o      = i;
        primed = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/in_pass_pipe.sv
// rtl/in_pass_pipe.sv - parametrised input pass/register BEL with shared counters and per-lane modes
module in_pass_pipe
  import in_pass_pipe_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 3
) (
  input  logic                  UserCLK,
  input  logic                  RST_N,
  input  logic [CHANNELS-1:0]   I,
  input  logic                  CE,
  input  logic [2*CHANNELS-1:0] ConfigBits,
  output logic [CHANNELS-1:0]   O,
  output logic [CHANNELS-1:0]   Primed
);

  localparam int             FW       = fill_width(DEPTH);
  localparam logic [FW-1:0]  FILL_MAX = FW'(DEPTH);

  logic [FW-1:0] fill_cnt;
  logic [1:0]    sync_cnt;
  logic          fill_full;
  logic          fill_nonzero;
  logic          sync_done;

  // Both counters saturate so Primed never falls back while running.
  always_ff @(posedge UserCLK or negedge RST_N) begin
    if (!RST_N) begin
      fill_cnt <= '0;
    end else if (CE && (fill_cnt != FILL_MAX)) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge UserCLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_cnt <= '0;
    end else if (sync_cnt != 2'd2) begin
      sync_cnt <= sync_cnt + 2'd1;
    end
  end

  assign fill_full    = (fill_cnt == FILL_MAX);
  assign fill_nonzero = (fill_cnt != '0);
  assign sync_done    = (sync_cnt == 2'd2);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
    in_pass_pipe_lane #(
      .DEPTH(DEPTH)
    ) u_lane (
      .clk         (UserCLK),
      .rst_n       (RST_N),
      .ce          (CE),
      .i           (I[n]),
      .mode        (ConfigBits[2*n +: 2]),
      .fill_full   (fill_full),
      .fill_nonzero(fill_nonzero),
      .sync_done   (sync_done),
      .o           (O[n]),
      .primed      (Primed[n])
    );
  end

endmodule

// File: tb/tb_in_pass_pipe.sv
// tb/tb_in_pass_pipe.sv - self-checking bench for in_pass_pipe (vector table, corner sequences, random vs model)
module tb_in_pass_pipe;

  localparam int CH    = 4;
  localparam int DEPTH = 3;

  logic          UserCLK;
  logic          RST_N;
  logic [CH-1:0] I;
  logic          CE;
  logic [7:0]    ConfigBits;
  logic [CH-1:0] O;
  logic [CH-1:0] Primed;

  int n_checks = 0;
  int n_fail   = 0;

  in_pass_pipe #(
    .CHANNELS(CH),
    .DEPTH   (DEPTH)
  ) dut (
    .UserCLK   (UserCLK),
    .RST_N     (RST_N),
    .I         (I),
    .CE        (CE),
    .ConfigBits(ConfigBits),
    .O         (O),
    .Primed    (Primed)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  // Reference model: histories of sampled inputs, newest first.
  logic [CH-1:0] ce_hist[$];
  logic [CH-1:0] clk_hist[$];

  task automatic model_reset();
    ce_hist.delete();
    clk_hist.delete();
  endtask

  task automatic model_step(input logic [CH-1:0] iv, input logic cev);
    clk_hist.push_front(iv);
    if (clk_hist.size() > 2) void'(clk_hist.pop_back());
    if (cev) begin
      ce_hist.push_front(iv);
      if (ce_hist.size() > DEPTH) void'(ce_hist.pop_back());
    end
  endtask

  task automatic model_expect(output logic [CH-1:0] eo, output logic [CH-1:0] ep);
    for (int n = 0; n < CH; n++) begin
      case (ConfigBits[2*n +: 2])
        2'b00: begin eo[n] = I[n]; ep[n] = 1'b1; end
        2'b01: begin
          eo[n] = (ce_hist.size() >= 1) ? ce_hist[0][n] : 1'b0;
          ep[n] = (ce_hist.size() >= 1);
        end
        2'b10: begin
          eo[n] = (ce_hist.size() >= DEPTH) ? ce_hist[DEPTH-1][n] : 1'b0;
          ep[n] = (ce_hist.size() >= DEPTH);
        end
        default: begin
          eo[n] = (clk_hist.size() >= 2) ? clk_hist[1][n] : 1'b0;
          ep[n] = (clk_hist.size() >= 2);
        end
      endcase
    end
  endtask

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [CH-1:0] eo, ep;
    model_expect(eo, ep);
    check({tag, "_O"}, O, eo);
    check({tag, "_Primed"}, Primed, ep);
  endtask

  task automatic edge_step();
    @(posedge UserCLK);
    if (RST_N) model_step(I, CE);
    #2;
  endtask

  task automatic do_reset();
    @(negedge UserCLK);
    #1;
    RST_N = 1'b0;
    model_reset();
    #1;
    RST_N = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    bit         clk;
    logic [7:0] cfg;
    logic       ce;
    logic [3:0] i;
    logic [3:0] exp_o;
    logic [3:0] exp_p;
    string      name;
  } vec_t;

  vec_t vt[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N      = 1'b0;
    I          = '0;
    CE         = 1'b0;
    ConfigBits = 8'h00;
    model_reset();

    // COMB lanes follow I even while reset is held; registered lanes stay at 0.
    #1; I = 4'b1010;
    #1; check("rst_comb_O", O, 4'b1010);
        check("rst_comb_Primed", Primed, 4'hF);
    I = 4'b0101;
    #1; check("rst_comb_follow", O, 4'b0101);
    ConfigBits = 8'h55;
    #1; check("rst_reg_O", O, 4'h0);
        check("rst_reg_Primed", Primed, 4'h0);

    //          rst  clk  cfg    ce  i     exp_o exp_p
    vt.push_back('{1, 1, 8'h55, 1, 4'hA, 4'hA, 4'hF, "reg_load"});
    vt.push_back('{0, 1, 8'h55, 0, 4'h5, 4'hA, 4'hF, "reg_hold1"});
    vt.push_back('{0, 1, 8'h55, 0, 4'h5, 4'hA, 4'hF, "reg_hold2"});
    vt.push_back('{0, 1, 8'h55, 0, 4'h5, 4'hA, 4'hF, "reg_hold3"});
    vt.push_back('{1, 1, 8'hAA, 1, 4'h1, 4'h0, 4'h0, "dly_e1"});
    vt.push_back('{0, 1, 8'hAA, 1, 4'h0, 4'h0, 4'h0, "dly_e2"});
    vt.push_back('{0, 1, 8'hAA, 1, 4'h1, 4'h1, 4'hF, "dly_e3"});
    vt.push_back('{0, 1, 8'hAA, 1, 4'h1, 4'h0, 4'hF, "dly_e4"});
    vt.push_back('{0, 1, 8'hAA, 1, 4'h0, 4'h1, 4'hF, "dly_e5"});
    vt.push_back('{0, 1, 8'hAA, 1, 4'h0, 4'h1, 4'hF, "dly_e6"});
    vt.push_back('{0, 1, 8'hAA, 1, 4'h0, 4'h0, 4'hF, "dly_e7"});
    vt.push_back('{1, 1, 8'hFF, 0, 4'hF, 4'h0, 4'h0, "sync_e1"});
    vt.push_back('{0, 1, 8'hFF, 0, 4'hF, 4'hF, 4'hF, "sync_e2"});
    vt.push_back('{1, 1, 8'hE4, 1, 4'hF, 4'h3, 4'h3, "mix_e1"});
    vt.push_back('{0, 1, 8'hE4, 1, 4'h0, 4'h8, 4'hB, "mix_e2"});
    vt.push_back('{0, 1, 8'hE4, 1, 4'h0, 4'h4, 4'hF, "mix_e3"});
    vt.push_back('{0, 1, 8'hE4, 1, 4'h0, 4'h0, 4'hF, "mix_e4"});
    vt.push_back('{0, 1, 8'hE4, 1, 4'hF, 4'h3, 4'hF, "mix_e5"});
    vt.push_back('{0, 0, 8'hE8, 1, 4'hF, 4'h1, 4'hF, "mix_reconfig"});
    vt.push_back('{0, 1, 8'hE8, 1, 4'h0, 4'h8, 4'hF, "mix_e6"});

    foreach (vt[k]) begin
      if (vt[k].rst) do_reset();
      ConfigBits = vt[k].cfg;
      CE         = vt[k].ce;
      I          = vt[k].i;
      if (vt[k].clk) edge_step();
      else #1;
      check({vt[k].name, "_O"}, O, vt[k].exp_o);
      check({vt[k].name, "_Primed"}, Primed, vt[k].exp_p);
    end

    // Fill counter saturates: 20 further CE edges in DELAY keep Primed high.
    ConfigBits = 8'hAA;
    for (int k = 0; k < 20; k++) begin
      CE = 1'b1;
      I  = 4'($urandom);
      edge_step();
      check("dly_sat_Primed", Primed, 4'hF);
    end
    check_model("dly_sat_end");

    // Asynchronous reset between edges, then refill from zero.
    do_reset();
    ConfigBits = 8'h55; CE = 1'b1; I = 4'hF;
    edge_step();
    check("async_pre_O", O, 4'hF);
    #3;
    RST_N = 1'b0;
    model_reset();
    #1;
    check("async_mid_O", O, 4'h0);
    check("async_mid_Primed", Primed, 4'h0);
    #1;
    RST_N = 1'b1;
    ConfigBits = 8'hAA;
    edge_step(); check("refill1_Primed", Primed, 4'h0);
    edge_step(); check("refill2_Primed", Primed, 4'h0);
    edge_step(); check("refill3_Primed", Primed, 4'hF);
                 check("refill3_O", O, 4'hF);

    // Randomised run against the reference model.
    do_reset();
    ConfigBits = 8'($urandom);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) ConfigBits = 8'($urandom);
      CE = 1'($urandom_range(0, 1));
      I  = 4'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        RST_N = 1'b0;
        model_reset();
        #1;
        check_model("rnd_rst");
        #1;
        RST_N = 1'b1;
      end
      edge_step();
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
